// File: rtl/fantasy_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : fantasy_mixer_if
// Purpose  : Pixel-stream bundle for the fantasy_mixer output stage. Carries
//            the stage-0 pixel inputs and the LAT-delayed mixed outputs.
// Ports    : hs_i/vs_i/de_i/blk_x_i  sync, enable and invert flag, stage 0
//            a_data_i/b_data_i       input-side and loop-back pixels
//            data_o                  mixed pixel
//            hs_o/vs_o/de_o/px_inv_o delayed syncs and invert decision
// Modports : master (pixel source / bench), slave (mixer)
// Revision : 1.0  initial release
// ============================================================================
interface fantasy_mixer_if #(
  parameter int NCH = 3,
  parameter int CW  = 8
);
  logic                hs_i;
  logic                vs_i;
  logic                de_i;
  logic                blk_x_i;
  logic [NCH*CW-1:0]   a_data_i;
  logic [NCH*CW-1:0]   b_data_i;
  logic [NCH*CW-1:0]   data_o;
  logic                hs_o;
  logic                vs_o;
  logic                de_o;
  logic                px_inv_o;

  modport master (
    output hs_i, vs_i, de_i, blk_x_i, a_data_i, b_data_i,
    input  data_o, hs_o, vs_o, de_o, px_inv_o
  );

  modport slave (
    input  hs_i, vs_i, de_i, blk_x_i, a_data_i, b_data_i,
    output data_o, hs_o, vs_o, de_o, px_inv_o
  );
endinterface
`default_nettype wire

// File: rtl/fantasy_mixer.sv
`default_nettype none
// ============================================================================
// Module   : fantasy_mixer
// Purpose  : Output stage of the dark-fantasy pipeline. Selects the source
//            pixel stream, applies the per-pixel invert decision and fades the
//            invert strength frame by frame. Switches are synchronised,
//            debounced and committed only on a vs rising edge.
// Ports    : clk_i      pixel clock
//            rst_i      synchronous active-high reset
//            mode_i     async mode switches (00 auto, 01 pass, 10 force,
//                       11 auto-inverse)
//            src_sel_i  async source switch (1 = a_data_i, 0 = b_data_i)
//            px         pixel bundle (slave side), outputs delayed by 2
//            fading_o   high while invert strength differs from its target
//            hb_o       heartbeat
// Revision : 1.0  initial release
// ============================================================================
module fantasy_mixer #(
  parameter int NCH        = 3,
  parameter int CW         = 8,
  parameter int FW         = 8,
  parameter int FADE_STEP  = 8,
  parameter int DEB_CYCLES = 1024,
  parameter int HB_BIT     = 26
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           mode_i,
  input  logic                 src_sel_i,
  fantasy_mixer_if.slave       px,
  output logic                 fading_o,
  output logic                 hb_o
);

  localparam int              S       = 1 << FW;
  localparam int              PW      = NCH * CW;
  localparam int              AW      = FW + 1;
  localparam int              ACCW    = CW + FW + 1;
  localparam int              DCW     = $clog2(DEB_CYCLES + 1);
  // A step larger than full strength behaves exactly like a step of S.
  localparam int              STEP_C  = (FADE_STEP > S) ? S : FADE_STEP;
  localparam logic [AW-1:0]   A_FULL  = AW'(S);
  localparam logic [AW-1:0]   STEP_A  = AW'(STEP_C);
  localparam logic [CW-1:0]   PIX_MAX = '1;

  localparam logic [1:0] MODE_AUTO    = 2'b00;
  localparam logic [1:0] MODE_PASS    = 2'b01;
  localparam logic [1:0] MODE_FORCE   = 2'b10;
  localparam logic [1:0] MODE_AUTOINV = 2'b11;

  function automatic logic [AW-1:0] tgt_of(input logic [1:0] m);
    return (m == MODE_PASS) ? '0 : A_FULL;
  endfunction

  // Move a toward t by at most STEP_A, landing exactly on t.
  function automatic logic [AW-1:0] fade_step(input logic [AW-1:0] a,
                                              input logic [AW-1:0] t);
    logic [AW-1:0] r;
    r = t;
    if (a < t) begin
      if ((t - a) > STEP_A) r = a + STEP_A;
    end else if (a > t) begin
      if ((a - t) > STEP_A) r = a - STEP_A;
    end
    return r;
  endfunction

  // ---------------- switch synchroniser and debounce ----------------
  logic [1:0]     mode_s1_q, mode_s2_q;
  logic           src_s1_q, src_s2_q;
  logic [2:0]     sw_sync;
  logic [2:0]     stab_q;     // candidate value being timed
  logic [2:0]     pend_q;     // last accepted {src_sel, mode}
  logic [DCW-1:0] deb_cnt_q;  // cycles the candidate has been seen

  assign sw_sync = {src_s2_q, mode_s2_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_s1_q <= '0;
      mode_s2_q <= '0;
      src_s1_q  <= 1'b0;
      src_s2_q  <= 1'b0;
      stab_q    <= {1'b0, MODE_PASS};
      pend_q    <= {1'b0, MODE_PASS};
      deb_cnt_q <= '0;
    end else begin
      mode_s1_q <= mode_i;
      mode_s2_q <= mode_s1_q;
      src_s1_q  <= src_sel_i;
      src_s2_q  <= src_s1_q;
      if (sw_sync != stab_q) begin
        stab_q    <= sw_sync;
        deb_cnt_q <= DCW'(1);
      end else begin
        if (deb_cnt_q < DCW'(DEB_CYCLES)) deb_cnt_q <= deb_cnt_q + 1'b1;
        if (deb_cnt_q >= DCW'(DEB_CYCLES)) pend_q <= stab_q;
      end
    end
  end

  // ---------------- frame-start commit and fade ----------------
  logic          vs_prev_q;
  logic          vs_rise;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    last_q, last_d;
  logic          src_q, src_d;
  logic [AW-1:0] a_q, a_d, tgt_d;
  logic          fading_q;

  assign vs_rise = px.vs_i & ~vs_prev_q;

  always_comb begin
    mode_d = mode_q;
    last_d = last_q;
    src_d  = src_q;
    a_d    = a_q;
    if (vs_rise) begin
      mode_d = pend_q[1:0];
      src_d  = pend_q[2];
      // Remember the last visible pattern so a fade-out keeps using it.
      if (pend_q[1:0] != MODE_PASS) last_d = pend_q[1:0];
      a_d = fade_step(a_q, tgt_of(pend_q[1:0]));
    end
    tgt_d = tgt_of(mode_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // vs_prev starts high so a reset during vs does not count as an edge.
      vs_prev_q <= 1'b1;
      mode_q    <= MODE_PASS;
      last_q    <= MODE_AUTO;
      src_q     <= 1'b0;
      a_q       <= '0;
      fading_q  <= 1'b0;
    end else begin
      vs_prev_q <= px.vs_i;
      mode_q    <= mode_d;
      last_q    <= last_d;
      src_q     <= src_d;
      a_q       <= a_d;
      fading_q  <= (a_d != tgt_d);
    end
  end

  assign fading_o = fading_q;

  // ---------------- stage-0 invert decision ----------------
  logic [1:0] dmode;
  logic       inv0;

  always_comb begin
    dmode = (mode_q == MODE_PASS) ? last_q : mode_q;
    inv0  = 1'b0;
    case (dmode)
      MODE_AUTO:    inv0 = px.blk_x_i;
      MODE_FORCE:   inv0 = 1'b1;
      MODE_AUTOINV: inv0 = ~px.blk_x_i;
      default:      inv0 = 1'b0;
    endcase
  end

  // ---------------- stage 1 ----------------
  logic [PW-1:0] s1_px_q;
  logic          s1_inv_q;
  logic [AW-1:0] s1_a_q;
  logic          s1_hs_q, s1_vs_q, s1_de_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_px_q  <= '0;
      s1_inv_q <= 1'b0;
      s1_a_q   <= '0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_de_q  <= 1'b0;
    end else begin
      s1_px_q  <= src_q ? px.a_data_i : px.b_data_i;
      s1_inv_q <= inv0;
      s1_a_q   <= a_q;
      s1_hs_q  <= px.hs_i;
      s1_vs_q  <= px.vs_i;
      s1_de_q  <= px.de_i;
    end
  end

  // ---------------- per-channel blend ----------------
  // y = (x*(S-a) + (M-x)*a) >> FW; the sum never exceeds M*S, so the
  // shifted result always fits in CW bits.
  logic [PW-1:0] mix_px;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [CW-1:0]   x;
    logic [ACCW-1:0] acc;
    assign x   = s1_px_q[ch*CW +: CW];
    assign acc = ACCW'(x) * ACCW'(A_FULL - s1_a_q)
               + ACCW'(PIX_MAX - x) * ACCW'(s1_a_q);
    assign mix_px[ch*CW +: CW] = s1_inv_q ? acc[FW +: CW] : x;
  end

  // ---------------- stage 2 ----------------
  logic [PW-1:0] s2_px_q;
  logic          s2_inv_q, s2_hs_q, s2_vs_q, s2_de_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_px_q  <= '0;
      s2_inv_q <= 1'b0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
      s2_de_q  <= 1'b0;
    end else begin
      s2_px_q  <= mix_px;
      s2_inv_q <= s1_inv_q;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      s2_de_q  <= s1_de_q;
    end
  end

  assign px.data_o   = s2_px_q;
  assign px.px_inv_o = s2_inv_q;
  assign px.hs_o     = s2_hs_q;
  assign px.vs_o     = s2_vs_q;
  assign px.de_o     = s2_de_q;

  // ---------------- heartbeat ----------------
  // Bits above HB_BIT never reach hb_o, so the counter stops at HB_BIT; the
  // visible bit toggles exactly as in a wrapping 32-bit counter.
  logic [HB_BIT:0] hb_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) hb_cnt_q <= '0;
    else       hb_cnt_q <= hb_cnt_q + 1'b1;
  end

  assign hb_o = hb_cnt_q[HB_BIT];

endmodule
`default_nettype wire

// File: tb/tb_fantasy_mixer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fantasy_mixer
// Purpose  : Self-checking bench for fantasy_mixer. Random pixels, scripted
//            switch scenarios, reference model at frame/pixel level.
// Revision : 1.0  initial release
// ============================================================================
module tb_fantasy_mixer;

  localparam int NCH       = 3;
  localparam int CW        = 8;
  localparam int FW        = 8;
  localparam int FADE_STEP = 8;
  localparam int DEB       = 16;
  localparam int HB_BIT    = 4;
  localparam int S         = 1 << FW;
  localparam int PW        = NCH * CW;
  localparam int FL        = 64;  // cycles per frame

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b01;
  logic       src = 1'b1;
  logic       fading;
  logic       hb;

  fantasy_mixer_if #(.NCH(NCH), .CW(CW)) pif ();

  fantasy_mixer #(
    .NCH(NCH), .CW(CW), .FW(FW), .FADE_STEP(FADE_STEP),
    .DEB_CYCLES(DEB), .HB_BIT(HB_BIT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .mode_i   (mode),
    .src_sel_i(src),
    .px       (pif.slave),
    .fading_o (fading),
    .hb_o     (hb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          hs;
    logic          vs;
    logic          de;
    logic          inv;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state, expressed in frame-level terms.
  int         m_a;
  logic [1:0] m_mode, m_last;
  logic       m_src;
  logic [2:0] m_pend, m_sw_prev;
  int         m_held;
  logic       m_vs_prev;
  int         m_hb;
  bit         started = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int tgt(input logic [1:0] m);
    return (m == 2'b01) ? 0 : S;
  endfunction

  function automatic logic [PW-1:0] mix_ref(input logic [PW-1:0] p, input bit inv, input int a);
    logic [PW-1:0] r;
    int x;
    r = p;
    if (inv) begin
      for (int ch = 0; ch < NCH; ch++) begin
        x = int'(p[ch*CW +: CW]);
        r[ch*CW +: CW] = CW'((x * (S - a) + ((1 << CW) - 1 - x) * a) / S);
      end
    end
    return r;
  endfunction

  function automatic bit inv_ref(input logic [1:0] md, input logic [1:0] last, input logic blk);
    logic [1:0] d;
    d = (md == 2'b01) ? last : md;
    if (d == 2'b00) return blk;
    if (d == 2'b10) return 1'b1;
    if (d == 2'b11) return ~blk;
    return 1'b0;
  endfunction

  // One clock: check outputs of the edge just passed, then apply new inputs
  // and advance the reference model by the same edge they will be sampled on.
  task automatic step(input bit r, input logic [1:0] md, input logic sr,
                      input logic vs_v, input logic hs_v, input logic de_v,
                      input logic blk_v, input logic [PW-1:0] ad, input logic [PW-1:0] bd);
    exp_t       e;
    logic [2:0] sw;
    int         t;
    @(posedge clk);
    #1;
    if (started) begin
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        chk("data_o",   pif.data_o,   e.data);
        chk("px_inv_o", pif.px_inv_o, e.inv);
        chk("hs_o",     pif.hs_o,     e.hs);
        chk("vs_o",     pif.vs_o,     e.vs);
        chk("de_o",     pif.de_o,     e.de);
      end
      chk("fading_o", fading, (m_a != tgt(m_mode)));
      chk("hb_o", hb, m_hb[HB_BIT]);
    end
    rst          = r;
    mode         = md;
    src          = sr;
    pif.vs_i     = vs_v;
    pif.hs_i     = hs_v;
    pif.de_i     = de_v;
    pif.blk_x_i  = blk_v;
    pif.a_data_i = ad;
    pif.b_data_i = bd;
    sw = {sr, md};
    if (r) begin
      started = 1;
      exp_q.delete();
      e = '0;
      exp_q.push_back(e);
      exp_q.push_back(e);
      m_a = 0; m_mode = 2'b01; m_last = 2'b00; m_src = 1'b0;
      m_pend = 3'b001; m_held = 0; m_vs_prev = 1'b1; m_hb = 0;
    end else begin
      // A switch value held well past the debounce time counts as accepted.
      if (sw != m_sw_prev) m_held = 1;
      else                 m_held++;
      if (m_held >= DEB + 5) m_pend = sw;
      e.inv  = inv_ref(m_mode, m_last, blk_v);
      e.data = mix_ref(m_src ? ad : bd, e.inv, m_a);
      e.hs   = hs_v;
      e.vs   = vs_v;
      e.de   = de_v;
      exp_q.push_back(e);
      if (vs_v && !m_vs_prev) begin
        m_mode = m_pend[1:0];
        m_src  = m_pend[2];
        if (m_mode != 2'b01) m_last = m_mode;
        t = tgt(m_mode);
        if (m_a < t) m_a = (m_a + FADE_STEP > t) ? t : m_a + FADE_STEP;
        else         m_a = (m_a - FADE_STEP < t) ? t : m_a - FADE_STEP;
      end
      m_vs_prev = vs_v;
      m_hb++;
    end
    m_sw_prev = sw;
  endtask

  // Runs n frames. Switches move to {sr,md} at cycle 4 of the first frame;
  // with glitch > 0 they revert after that many cycles. rst_c >= 0 pulses
  // reset at that cycle of the first frame. directed drives x=0x10 on every
  // channel with blk_x alternating per pixel.
  task automatic frames(input int n, input logic [1:0] md, input logic sr,
                        input int glitch, input int rst_c, input bit directed);
    logic [1:0]    cur_md, prev_md;
    logic          cur_sr, prev_sr;
    logic [PW-1:0] ad, bd;
    logic          blk;
    prev_md = mode;
    prev_sr = src;
    cur_md  = mode;
    cur_sr  = src;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FL; c++) begin
        if (f == 0 && c == 4) begin
          cur_md = md;
          cur_sr = sr;
        end
        if (f == 0 && glitch > 0 && c == 4 + glitch) begin
          cur_md = prev_md;
          cur_sr = prev_sr;
        end
        if (directed) begin
          ad  = {NCH{8'h10}};
          bd  = {NCH{8'h10}};
          blk = (c % 2) == 1;
        end else begin
          ad  = PW'($urandom);
          bd  = PW'($urandom);
          blk = 1'($urandom);
        end
        step((f == 0 && c == rst_c), cur_md, cur_sr, (c < 2), ((c % 16) < 2),
             (c >= 8 && (c % 16) >= 3), blk, ad, bd);
      end
    end
  endtask

  initial begin
    pif.hs_i = 1'b0; pif.vs_i = 1'b0; pif.de_i = 1'b0; pif.blk_x_i = 1'b0;
    pif.a_data_i = '0; pif.b_data_i = '0;
    repeat (4) step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    frames(3,  2'b01, 1'b1, 0,       -1,     1'b0);  // pass, source a
    frames(34, 2'b10, 1'b1, 0,       -1,     1'b0);  // fade in to full force
    frames(3,  2'b00, 1'b1, 0,       -1,     1'b1);  // auto, 0x10 alternating
    frames(3,  2'b11, 1'b1, DEB - 1, -1,     1'b0);  // short glitch, ignored
    frames(2,  2'b10, 1'b0, 0,       -1,     1'b0);  // force, source b
    frames(16, 2'b01, 1'b0, 0,       -1,     1'b0);  // fade out to 128
    frames(18, 2'b10, 1'b0, 0,       -1,     1'b0);  // reverse, climb to full
    frames(3,  2'b11, 1'b0, 0,       -1,     1'b0);  // auto-inverse
    frames(2,  2'b11, 1'b0, 0,       FL - 8, 1'b0);  // reset late in frame
    frames(4,  2'b11, 1'b0, 0,       -1,     1'b0);  // re-accepted after reset
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
